// File: rtl/dram_pkg.sv
// Shared definitions for the toy x16 8n-prefetch DRAM command interface,
// imported by both the IO controller and the DRAM responder model.
package dram_pkg;

  typedef enum logic [2:0] {
    REFRESH   = 3'b001,
    PRECHARGE = 3'b010,
    ACTIVATE  = 3'b011,
    WRITE     = 3'b100,
    READ      = 3'b101,
    NOP       = 3'b111
  } dram_cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    LAT,
    BEAT0,
    BEAT1,
    BEAT2,
    BEAT3
  } dram_state_t;

  localparam int ROW_BITS  = 14;
  localparam int COL_BITS  = 10;
  localparam int BANK_BITS = 3;
  localparam int NUM_BANKS = 1 << BANK_BITS;
  localparam int ADDR_BITS = 14;

  localparam logic [ADDR_BITS-1:0] BAD_ADDR = 14'h3BAD;

endpackage

// File: rtl/toy_dram_bank_tracker.sv
// Per-bank open/row bookkeeping for the toy DRAM model: decodes
// ACTIVATE/PRECHARGE and flags a REFRESH issued while any bank is open.
module toy_dram_bank_tracker
  import dram_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 cs,
  input  logic [2:0]           cmd,
  input  logic [BANK_BITS-1:0] bank,
  input  logic [ADDR_BITS-1:0] addr,
  output logic                 is_open,
  output logic [ROW_BITS-1:0]  row,
  output logic                 refresh_err
);

  logic [NUM_BANKS-1:0] bank_open;
  logic [ROW_BITS-1:0]  open_row [NUM_BANKS];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bank_open <= '0;
      for (int b = 0; b < NUM_BANKS; b++) open_row[b] <= '0;
    end else if (cs) begin
      if (cmd == ACTIVATE) begin
        bank_open[bank] <= 1'b1;
        open_row[bank]  <= addr;
      end else if (cmd == PRECHARGE) begin
        bank_open[bank] <= 1'b0;
      end
    end
  end

  assign is_open     = bank_open[bank];
  assign row         = open_row[bank];
  assign refresh_err = cs && (cmd == REFRESH) && (|bank_open);

endmodule

// File: rtl/toy_dram_model.sv
// Behavioural DRAM responder: returns a 128-bit word as four 2x16-bit beats
// after READ_LAT cycles, with a backdoor load port for preloading storage.
module toy_dram_model
  import dram_pkg::*;
#(
  parameter int          READ_LAT     = 2,
  parameter int          ROW_IDX_BITS = 1,
  parameter logic [15:0] ERR_DATA     = 16'hDEAD,
  localparam int         MEM_AW       = BANK_BITS + ROW_IDX_BITS + 7
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 io2dram_cs,
  input  logic [2:0]           io2dram_cmd,
  input  logic [ADDR_BITS-1:0] io2dram_addr,
  input  logic [BANK_BITS-1:0] io2dram_bank,
  output logic [15:0]          io2dram_data [0:1],
  input  logic                 load_en,
  input  logic [MEM_AW-1:0]    load_addr,
  input  logic [15:0]          load_data [0:7],
  output logic                 proto_err,
  output logic                 busy
);

  typedef logic [7:0][15:0] word_t;

  word_t               mem [2**MEM_AW];
  word_t               load_word;
  word_t               fetch_word;
  word_t               beat_word;
  word_t               hold;
  dram_state_t         state;
  dram_state_t         state_next;
  logic [7:0]          lat_cnt;
  logic                is_open;
  logic                refresh_err;
  logic [ROW_BITS-1:0] row;
  logic                rd_cmd;
  logic                accept;
  logic [MEM_AW-1:0]   rd_idx;
  logic [15:0]         data_d [0:1];
  logic                err_d;
  logic                busy_d;
  logic                beat_valid;
  logic [1:0]          beat_sel;
  logic                unused_row;

  toy_dram_bank_tracker u_tracker (
    .clock       (clock),
    .reset       (reset),
    .cs          (io2dram_cs),
    .cmd         (io2dram_cmd),
    .bank        (io2dram_bank),
    .addr        (io2dram_addr),
    .is_open     (is_open),
    .row         (row),
    .refresh_err (refresh_err)
  );

  assign unused_row = ^row[ROW_BITS-1:ROW_IDX_BITS];
  assign rd_cmd     = io2dram_cs && (io2dram_cmd == READ);
  assign accept     = rd_cmd && (state == IDLE);
  assign rd_idx     = {io2dram_bank, row[ROW_IDX_BITS-1:0], io2dram_addr[9:3]};
  // A READ to a closed bank still bursts, but with the error pattern.
  assign fetch_word = is_open ? mem[rd_idx] : {8{ERR_DATA}};

  always_comb begin
    load_word = '0;
    for (int k = 0; k < 8; k++) load_word[k] = load_data[k];
  end

  always_ff @(posedge clock) begin
    if (load_en) mem[load_addr] <= load_word;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      lat_cnt <= '0;
      hold    <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        lat_cnt <= 8'(READ_LAT - 1);
        hold    <= fetch_word;
      end else if (state == LAT) begin
        lat_cnt <= lat_cnt - 8'd1;
      end
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (READ_LAT <= 1) ? BEAT0 : LAT;
      LAT:     if (lat_cnt <= 8'd1) state_next = BEAT0;
      BEAT0:   state_next = BEAT1;
      BEAT1:   state_next = BEAT2;
      BEAT2:   state_next = BEAT3;
      BEAT3:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Beat 0 can leave on the accept edge itself, before hold is loaded.
  always_comb begin
    beat_word  = (state == IDLE) ? fetch_word : hold;
    beat_valid = 1'b1;
    beat_sel   = 2'd0;
    data_d[0]  = '0;
    data_d[1]  = '0;
    case (state_next)
      BEAT0:   beat_sel = 2'd0;
      BEAT1:   beat_sel = 2'd1;
      BEAT2:   beat_sel = 2'd2;
      BEAT3:   beat_sel = 2'd3;
      default: beat_valid = 1'b0;
    endcase
    if (beat_valid) begin
      data_d[0] = beat_word[{beat_sel, 1'b0}];
      data_d[1] = beat_word[{beat_sel, 1'b1}];
    end
    busy_d = (state_next != IDLE);
    err_d  = refresh_err
           | (rd_cmd && ((state != IDLE) || !is_open))
           | (io2dram_cs && (io2dram_cmd == WRITE))
           | (io2dram_cs && ((io2dram_cmd == 3'b000) || (io2dram_cmd == 3'b110)));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io2dram_data[0] <= '0;
      io2dram_data[1] <= '0;
      proto_err       <= 1'b0;
      busy            <= 1'b0;
    end else begin
      io2dram_data[0] <= data_d[0];
      io2dram_data[1] <= data_d[1];
      proto_err       <= err_d;
      busy            <= busy_d;
    end
  end

endmodule

// File: doc/toy_dram_model.md
Name: toy_dram_model

Overview:
- Behavioural responder for the toy x16, 8n-prefetch DRAM command interface; the DRAM-side counterpart of the IO controller.
- Decodes CS/CMD/ADDR/BANK, tracks the open row per bank, and returns a 128-bit word as four 2x16-bit beats on io2dram_data after a fixed read latency.
- Holds storage in an internal array, with a backdoor load port for bench preload.
- Used in block- and system-level simulation only. Not for synthesis to silicon.

Parameters:
- READ_LAT, 2: cycles from the cycle a READ is presented on the bus to the cycle beat 0 is on io2dram_data (minimum 1).
- ROW_IDX_BITS, 1: low row bits used in the storage index.
- MEM_AW, 3+ROW_IDX_BITS+7: storage word-address width (derived; do not override).
- ERR_DATA, 16'hDEAD: value driven on both lanes for a READ to a closed bank.

Ports:
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- io2dram_cs  in  1  chip select; commands are ignored when low.
- io2dram_cmd  in  3  dram_cmd_t command.
- io2dram_addr  in  14  row on ACTIVATE; {4'b0, col[9:0]} on READ/WRITE.
- io2dram_bank  in  3  bank select.
- io2dram_data  out  16 x [0:1]  read beat: lane 0 = even half-word, lane 1 = odd half-word.
- load_en  in  1  backdoor write strobe.
- load_addr  in  MEM_AW  backdoor word index.
- load_data  in  16 x [0:7]  backdoor 128-bit word.
- proto_err  out  1  one-cycle pulse on a protocol violation.
- busy  out  1  read burst in progress (latency or beats).

Behaviour:
- Reset (asynchronous, while high): io2dram_data = {0,0}; proto_err = 0; busy = 0; FSM = IDLE; all banks closed. Storage contents are untouched. Reset mid-burst aborts the burst; no further beats are driven.
- Command sampling: on each posedge with cs=1. When cs=0, or cmd=NOP, nothing happens.
- ACTIVATE: open_row[bank] <= addr; bank_open[bank] <= 1. Activating an already-open bank replaces the row with no error.
- PRECHARGE: bank_open[bank] <= 0. Legal on a closed bank (no-op).
- REFRESH: legal only if all banks are closed; otherwise pulse proto_err. There is no other effect.
- WRITE: data is not modelled. Pulse proto_err and leave storage unchanged.
- Undefined encodings (3'b000, 3'b110): pulse proto_err; otherwise treated as NOP.
- READ, bank open and FSM IDLE:
  - Latch word index = {bank, open_row[bank][ROW_IDX_BITS-1:0], addr[9:3]}; addr[2:0] is ignored.
  - Enter LAT with counter = READ_LAT-1; busy goes high on the same edge.
- READ to a closed bank: pulse proto_err and still run a full burst, with every beat = {ERR_DATA, ERR_DATA}.
- READ while busy: pulse proto_err; the command is dropped and the current burst is unaffected.
- FSM states: IDLE, LAT, BEAT0, BEAT1, BEAT2, BEAT3.
  - Timing: a READ sampled at edge E puts beat k on the bus in the cycle after edge E+READ_LAT-1+k.
  - With READ_LAT=2, a READ presented in cycle c gives beats in cycles c+2..c+5.
  - LAT: decrement the counter each edge. At 0, go to BEAT0 and register beat 0 onto the bus.
  - BEATk drives io2dram_data[0] = word[2k], io2dram_data[1] = word[2k+1].
  - BEAT3 -> IDLE. On exit, io2dram_data returns to 0 and busy falls.
  - READ_LAT=1: skip LAT and go straight from IDLE to BEAT0.
- Storage read: the word is captured into a 128-bit holding register at READ acceptance. Later loads or commands do not alter an in-flight burst.
- Backdoor load: on posedge with load_en=1, mem[load_addr] <= load_data. A load in the same cycle as an accepted READ to the same index: the READ captures the old contents.
- io2dram_data and proto_err are registered outputs with no combinational path from inputs.

Decomposition:
- Shared package dram_pkg:
  - dram_cmd_t: REFRESH=001, PRECHARGE=010, ACTIVATE=011, WRITE=100, READ=101, NOP=111.
  - BAD_ADDR = 14'h3BAD.
  - Row/col/bank width constants.
- The IO controller and this model both import dram_pkg.
- One sub-module: toy_dram_bank_tracker. It holds the per-bank open bit and row, decodes ACTIVATE/PRECHARGE/REFRESH, and reports open/row for a given bank plus the refresh error.

Test Plan:
- Preload mem[{3'd2,1'b0,7'd5}] = half-words 0x1000..0x1007; ACTIVATE row 0 bank 2 (cycle c-1); READ bank 2 col 0x028 (cycle c) -> beats (0x1000,0x1001) at c+2, (0x1002,0x1003) at c+3, (0x1004,0x1005) at c+4, (0x1006,0x1007) at c+5; data 0 at c+6; busy high c+1..c+5; no proto_err.
- READ bank 4 with no prior ACTIVATE -> proto_err pulse one cycle after the command; four beats of (0xDEAD,0xDEAD) at c+2..c+5.
- Second READ issued at c+3 during a burst -> proto_err pulse; original beats unchanged; no extra beats.
- ACTIVATE bank 1, then REFRESH -> proto_err. PRECHARGE bank 1, then REFRESH -> no error.
- READ with cs=0 -> no burst, busy stays 0, io2dram_data stays 0.
- Assert reset during BEAT1 -> io2dram_data=0, busy=0 immediately. After release, READ to the previously open bank -> proto_err (banks closed by reset).
